// File: rtl/intersection_request_conditioner.sv
// Conditions raw ped buttons and lane sensors into latched service requests:
// sync, debounce, car-presence qualification, phase-based clearing and wait timing.
module intersection_request_conditioner #(
    parameter int DEBOUNCE_MS   = 20,
    parameter int PRESENCE_MS   = 500,
    parameter int TICKS_PER_SEC = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] raw_in,
    input  logic [1:0] phase,
    output logic [5:0] req,
    output logic [2:0] req_count,
    output logic [7:0] oldest_wait
);
    localparam int DB_W = $clog2(DEBOUNCE_MS + 1);
    localparam int PR_W = $clog2(PRESENCE_MS + 1);
    localparam int PS_W = $clog2(TICKS_PER_SEC + 1);

    logic [5:0]            sync0_q, sync0_d, sync1_q, sync1_d;
    logic [5:0]            deb_q, deb_d, deb_prev_q, deb_prev_d;
    logic [5:0]            req_q, req_d;
    logic [5:0][DB_W-1:0]  dbc_q, dbc_d;
    logic [3:0][PR_W-1:0]  pres_q, pres_d;
    logic [5:0][7:0]       wait_q, wait_d;
    logic [PS_W-1:0]       presc_q, presc_d;
    logic [5:0]            served, set;
    logic                  tick;

    always_comb begin
        served = 6'b000000;
        case (phase)
            2'd0: served = 6'b000101;
            2'd1: served = 6'b001000;
            2'd2: served = 6'b010010;
            2'd3: served = 6'b100000;
            default: served = 6'b000000;
        endcase

        tick    = (presc_q == PS_W'(TICKS_PER_SEC - 1));
        presc_d = tick ? '0 : presc_q + PS_W'(1);

        sync0_d    = raw_in;
        sync1_d    = sync0_q;
        deb_prev_d = deb_q;
        deb_d      = deb_q;
        dbc_d      = '0;
        set        = '0;
        pres_d     = '0;
        req_d      = '0;
        wait_d     = '0;

        for (int i = 0; i < 6; i++) begin
            if (sync1_q[i] != deb_q[i]) begin
                if (dbc_q[i] == DB_W'(DEBOUNCE_MS - 1))
                    deb_d[i] = sync1_q[i];
                else
                    dbc_d[i] = dbc_q[i] + DB_W'(1);
            end
        end

        set[0] = deb_q[0] & ~deb_prev_q[0];
        set[1] = deb_q[1] & ~deb_prev_q[1];

        // Presence is held at zero during service so a waiting car re-qualifies afterwards.
        for (int j = 0; j < 4; j++) begin
            if (served[j+2] || !deb_q[j+2])
                pres_d[j] = '0;
            else if (pres_q[j] == PR_W'(PRESENCE_MS))
                pres_d[j] = pres_q[j];
            else
                pres_d[j] = pres_q[j] + PR_W'(1);
            set[j+2] = (pres_d[j] == PR_W'(PRESENCE_MS)) && (pres_q[j] != PR_W'(PRESENCE_MS));
        end

        for (int i = 0; i < 6; i++) begin
            req_d[i] = served[i] ? 1'b0 : (req_q[i] | set[i]);
            if (!req_d[i])
                wait_d[i] = 8'd0;
            else if (req_q[i] && tick && wait_q[i] != 8'd255)
                wait_d[i] = wait_q[i] + 8'd1;
            else
                wait_d[i] = wait_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync0_q    <= '0;
            sync1_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            dbc_q      <= '0;
            pres_q     <= '0;
            req_q      <= '0;
            wait_q     <= '0;
            presc_q    <= '0;
        end else begin
            sync0_q    <= sync0_d;
            sync1_q    <= sync1_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_prev_d;
            dbc_q      <= dbc_d;
            pres_q     <= pres_d;
            req_q      <= req_d;
            wait_q     <= wait_d;
            presc_q    <= presc_d;
        end
    end

    always_comb begin
        req         = req_q;
        req_count   = 3'd0;
        oldest_wait = 8'd0;
        for (int i = 0; i < 6; i++) begin
            req_count = req_count + 3'(req_q[i]);
            if (wait_q[i] > oldest_wait)
                oldest_wait = wait_q[i];
        end
    end
endmodule

// File: tb/tb_intersection_request_conditioner.sv
// Scoreboard bench: expectations are queued with a target cycle when stimulus is
// driven, and compared against the outputs at the falling edge of that cycle.
module tb_intersection_request_conditioner;
    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] raw_in;
    logic [1:0] phase;
    logic [5:0] req;
    logic [2:0] req_count;
    logic [7:0] oldest_wait;

    intersection_request_conditioner #(
        .DEBOUNCE_MS(20), .PRESENCE_MS(500), .TICKS_PER_SEC(10)
    ) dut (
        .clk(clk), .reset(reset), .raw_in(raw_in), .phase(phase),
        .req(req), .req_count(req_count), .oldest_wait(oldest_wait)
    );

    always #5 clk = ~clk;

    // sel: 0..5 single req bit, 6 whole req, 7 req_count, 8 oldest_wait
    typedef struct {
        int    at;
        string tag;
        int    sel;
        int    lo;
        int    hi;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic expect_at(input int dc, input string tag, input int sel, input int lo, input int hi);
        exp_t e;
        int   i;
        e.at = cyc + dc; e.tag = tag; e.sel = sel; e.lo = lo; e.hi = hi;
        i = 0;
        while (i < sb.size() && sb[i].at <= e.at) i++;
        sb.insert(i, e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        raw_in = '0;
        step(2);
        reset  = 1'b0;
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            exp_t e;
            int   obs;
            e = sb.pop_front();
            case (e.sel)
                6:       obs = int'(req);
                7:       obs = int'(req_count);
                8:       obs = int'(oldest_wait);
                default: obs = int'(req[e.sel]);
            endcase
            if (e.at < cyc)
                chk({e.tag, "_missed"}, 0, 1);
            else if (e.lo == e.hi)
                chk(e.tag, obs, e.lo);
            else
                chk({e.tag, "_in_range"}, (obs >= e.lo && obs <= e.hi) ? 1 : 0, 1);
        end
    end

    initial begin
        reset = 1'b1; raw_in = 6'h3F; phase = 2'd0;

        // reset held with all inputs high, then 20 quiet cycles after release
        step(1);
        for (int i = 0; i < 3; i++) begin
            expect_at(i, "rst_req", 6, 0, 0);
            expect_at(i, "rst_cnt", 7, 0, 0);
            expect_at(i, "rst_ow", 8, 0, 0);
        end
        step(2);
        reset = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            expect_at(i, "post_rst_req", 6, 0, 0);
            expect_at(i, "post_rst_ow", 8, 0, 0);
        end
        step(10); raw_in = '0; step(40);

        // ped button latch, hold after release, clear on phase 0
        do_reset(); phase = 2'd1; raw_in[0] = 1'b1;
        expect_at(22, "btn_early", 0, 0, 0);
        expect_at(23, "btn_rise", 0, 1, 1);
        expect_at(23, "btn_cnt", 7, 1, 1);
        step(30); raw_in[0] = 1'b0;
        expect_at(40, "btn_hold", 0, 1, 1);
        step(40); phase = 2'd0;
        expect_at(0, "btn_pre_clr", 0, 1, 1);
        expect_at(1, "btn_clr", 0, 0, 0);
        expect_at(1, "btn_clr_cnt", 7, 0, 0);
        step(5); phase = 2'd1;
        expect_at(10, "btn_stay_clr", 0, 0, 0);
        step(15);

        // glitch reject: 19-cycle pulse, bounce, then a 20-cycle pulse that must pass
        do_reset(); phase = 2'd1; raw_in[1] = 1'b1;
        step(19); raw_in[1] = 1'b0;
        expect_at(10, "glitch19", 1, 0, 0);
        expect_at(30, "glitch19_late", 1, 0, 0);
        step(40);
        for (int i = 0; i < 40; i++) begin
            raw_in[1] = ~raw_in[1];
            expect_at(2, "bounce", 1, 0, 0);
            step(5);
        end
        expect_at(30, "bounce_end", 1, 0, 0);
        step(40);
        raw_in[1] = 1'b1;
        expect_at(22, "pulse20_early", 1, 0, 0);
        expect_at(23, "pulse20", 1, 1, 1);
        step(20); raw_in[1] = 1'b0; step(40);

        // car presence
        do_reset(); phase = 2'd0; raw_in[5] = 1'b1;
        expect_at(521, "car_early", 5, 0, 0);
        expect_at(522, "car_rise", 5, 1, 1);
        step(600); raw_in[5] = 1'b0;
        expect_at(100, "car_hold", 5, 1, 1);
        step(150); phase = 2'd3;
        expect_at(1, "car_clr", 5, 0, 0);
        step(10);

        do_reset(); phase = 2'd0; raw_in[5] = 1'b1;
        step(300); raw_in[5] = 1'b0;
        expect_at(300, "car_short", 5, 0, 0);
        step(320);

        do_reset(); phase = 2'd3; raw_in[5] = 1'b1;
        expect_at(522, "car_served", 5, 0, 0);
        expect_at(599, "car_served_late", 5, 0, 0);
        step(600); phase = 2'd0;
        expect_at(499, "car_rereq_early", 5, 0, 0);
        expect_at(500, "car_rereq", 5, 1, 1);
        step(520); raw_in[5] = 1'b0; step(30);

        // wait counters (10 cycles per second)
        do_reset(); phase = 2'd2; raw_in[2] = 1'b1;
        expect_at(522, "wait_set", 2, 1, 1);
        expect_at(522, "wait_zero", 8, 0, 0);
        expect_at(557, "wait_35", 8, 2, 4);
        step(100); raw_in[3] = 1'b1;
        expect_at(521, "cnt_one", 7, 1, 1);
        expect_at(522, "cnt_two", 7, 2, 2);
        expect_at(522, "req_2_3", 6, 12, 12);
        expect_at(2422, "wait_200", 8, 199, 201);
        expect_at(3422, "wait_sat", 8, 255, 255);
        expect_at(3522, "wait_sat_hold", 8, 255, 255);
        step(3600); raw_in = '0; phase = 2'd0;
        expect_at(1, "svc2_clr", 2, 0, 0);
        expect_at(1, "svc2_cnt", 7, 1, 1);
        expect_at(1, "svc2_ow", 8, 255, 255);
        step(5); phase = 2'd1;
        expect_at(1, "svc3_ow", 8, 0, 0);
        expect_at(1, "svc3_cnt", 7, 0, 0);
        step(30);

        // set and clear in the same cycle: clear wins, edge discarded
        do_reset(); phase = 2'd1; raw_in[0] = 1'b1;
        step(22); phase = 2'd0;
        expect_at(1, "simul_clr", 0, 0, 0);
        expect_at(2, "simul_clr2", 0, 0, 0);
        step(8); phase = 2'd1;
        expect_at(10, "simul_discard", 0, 0, 0);
        raw_in[0] = 1'b0;
        step(30);

        // reset drops a pending request
        do_reset(); phase = 2'd1; raw_in[0] = 1'b1;
        expect_at(23, "pend", 0, 1, 1);
        step(30); raw_in[0] = 1'b0; reset = 1'b1;
        expect_at(1, "rst_drop", 6, 0, 0);
        step(1); reset = 1'b0;
        expect_at(30, "rst_drop_stay", 0, 0, 0);
        step(40);

        // reset in the middle of debouncing restarts the count
        phase = 2'd1; raw_in[1] = 1'b1;
        step(15); reset = 1'b1; step(1); reset = 1'b0;
        step(14); raw_in[1] = 1'b0;
        expect_at(40, "rst_mid_deb", 1, 0, 0);
        step(60);

        for (int i = 0; i < 2000 && sb.size() > 0; i++) step(1);
        if (sb.size() > 0) chk("sb_drain", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
